// File: rtl/branch_resolve_if.sv
// Branch-resolve bus: fetch prediction push, execute resolution, and
// redirect/flush back to the front end. The statistics counters are only
// present when BRANCH_STATS_EN is defined.
interface branch_resolve_if #(
    parameter int ALEN = 32
);
    logic            pred_valid;
    logic            pred_ready;
    logic            pred_taken;
    logic [ALEN-1:0] pred_next_pc;
    logic            resolve_valid;
    logic [ALEN-1:0] resolve_next_pc;
    logic            resolve_taken;
    logic            redirect_valid;
    logic [ALEN-1:0] redirect_pc;
    logic            flush;
    logic            order_error;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_resolved;
    logic [31:0]     stat_mispredict;
    logic [31:0]     stat_taken;

    // Front end / execute side (drives pushes and resolutions)
    modport master (
        output pred_valid, pred_taken, pred_next_pc,
        output resolve_valid, resolve_next_pc, resolve_taken,
        input  pred_ready, redirect_valid, redirect_pc, flush, order_error,
        input  stat_resolved, stat_mispredict, stat_taken
    );

    // Resolver side
    modport slave (
        input  pred_valid, pred_taken, pred_next_pc,
        input  resolve_valid, resolve_next_pc, resolve_taken,
        output pred_ready, redirect_valid, redirect_pc, flush, order_error,
        output stat_resolved, stat_mispredict, stat_taken
    );
`else
    // Front end / execute side (drives pushes and resolutions)
    modport master (
        output pred_valid, pred_taken, pred_next_pc,
        output resolve_valid, resolve_next_pc, resolve_taken,
        input  pred_ready, redirect_valid, redirect_pc, flush, order_error
    );

    // Resolver side
    modport slave (
        input  pred_valid, pred_taken, pred_next_pc,
        input  resolve_valid, resolve_next_pc, resolve_taken,
        output pred_ready, redirect_valid, redirect_pc, flush, order_error
    );
`endif
endinterface

// File: rtl/branch_resolve.sv
// Execute-side branch resolver. Fetch pushes predicted next PCs into an
// in-order FIFO; each in-order resolution is compared against the oldest
// record. A PC mismatch produces a one-cycle redirect and then holds flush
// for FLUSH_CYCLES cycles in total, clearing all queued predictions.
// Optional feature: define BRANCH_STATS_EN for saturating 32-bit counters.
module branch_resolve #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int ALEN         = 32
) (
    input logic             clk,
    input logic             rst,
    branch_resolve_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, REDIRECT, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ALEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic            flush_q, flush_d;
    logic            order_error_q, order_error_d;

    logic [ALEN-1:0] mem [DEPTH];

    logic            in_run, empty, full, pop, push, ready, mispredict;
    logic [ALEN-1:0] head_pc;

    // Taken bits are informational; folded here so they are visibly consumed.
    logic unused_taken;
    assign unused_taken = ^{bus.pred_taken, bus.resolve_taken};

    // FIFO status, handshake and head compare
    always_comb begin
        in_run     = (state_q == RUN);
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = bus.resolve_valid && in_run && !empty;
        ready      = in_run && (!full || pop);
        push       = bus.pred_valid && ready;
        head_pc    = mem[rd_ptr_q[AW-1:0]];
        mispredict = (head_pc != bus.resolve_next_pc);
    end

    // Next-state logic for the FSM, pointers and registered outputs
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        order_error_d = order_error_q;
        case (state_q)
            RUN: begin
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                if (pop && mispredict) begin
                    state_d       = REDIRECT;
                    redirect_pc_d = bus.resolve_next_pc;
                end
                if (bus.resolve_valid && empty) order_error_d = 1'b1;
            end
            REDIRECT: begin
                // Drop every queued record, including one pushed alongside the mismatch.
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = CW'(FLUSH_CYCLES - 1);
                state_d  = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            end
            FLUSH: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        redirect_valid_d = (state_d == REDIRECT);
        flush_d          = (state_d != RUN);
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q          <= RUN;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            order_error_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            order_error_q    <= order_error_d;
        end
    end

    // Prediction storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (push) mem[wr_ptr_q[AW-1:0]] <= bus.pred_next_pc;
    end

    assign bus.pred_ready     = ready;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = flush_q;
    assign bus.order_error    = order_error_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispredict_q, stat_mispredict_d;
    logic [31:0] stat_taken_q, stat_taken_d;

    // Saturating statistics, one step per pop
    always_comb begin
        stat_resolved_d   = stat_resolved_q;
        stat_mispredict_d = stat_mispredict_q;
        stat_taken_d      = stat_taken_q;
        if (pop) begin
            if (stat_resolved_q != '1) stat_resolved_d = stat_resolved_q + 1'b1;
            if (mispredict && stat_mispredict_q != '1)
                stat_mispredict_d = stat_mispredict_q + 1'b1;
            if (bus.resolve_taken && stat_taken_q != '1)
                stat_taken_d = stat_taken_q + 1'b1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
            stat_taken_q      <= '0;
        end else begin
            stat_resolved_q   <= stat_resolved_d;
            stat_mispredict_q <= stat_mispredict_d;
            stat_taken_q      <= stat_taken_d;
        end
    end

    assign bus.stat_resolved   = stat_resolved_q;
    assign bus.stat_mispredict = stat_mispredict_q;
    assign bus.stat_taken      = stat_taken_q;
`endif
endmodule
